seq101_frame_tx: RTL

Serial frame transmitter that drives the one-bit stream consumed by the team's non-overlapping Moore "101" detector (`moore_non_101`). It accepts a parallel payload word over a valid/ready handshake and emits it on a single-bit line as one frame:
- a fixed `101` preamble,
- the payload, MSB first,
- a run of zero gap bits.

The zero gap returns a downstream non-overlapping detector to its idle state between frames.

---
 rtl/seq101_frame_tx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq101_frame_tx.sv
// seq101_frame_tx: serial frame transmitter.
// Each accepted payload word goes out on a one-bit line as a frame:
// a "101" preamble, then the payload MSB first, then GAP zero bits.
// The trailing zeros return a downstream non-overlapping "101"
// detector to its idle state before the next frame begins.
module seq101_frame_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             R,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             busy,
  output logic             frame_done
);

  // One counter serves every state, so it is sized for the longest state.
  localparam int MAXL = (WIDTH > GAP) ? ((WIDTH > 3) ? WIDTH : 3)
                                      : ((GAP > 3) ? GAP : 3);
  localparam int CW   = $clog2(MAXL) + 1;

  // Counter value that marks the last bit of each state.
  localparam logic [CW-1:0] PRE_LAST  = CW'(2);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_GAP
  } state_t;

  state_t           state_reg,  state_next;
  logic [CW-1:0]    cnt_reg,    cnt_next;
  logic [WIDTH-1:0] shift_reg,  shift_next;
  logic             out_reg,    out_next;
  logic             done_reg,   done_next;

  // State, counter, payload and output registers; reset abandons any frame.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      out_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      out_reg   <= out_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic. cnt_reg always holds the index, within the current
  // state, of the bit that out_reg is presenting right now.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    out_next   = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // The first preamble bit is driven on the accept edge itself.
        if (in_valid) begin
          state_next = S_PRE;
          cnt_next   = '0;
          shift_next = in_data;
          out_next   = 1'b1;
        end
      end
      S_PRE: begin
        if (cnt_reg == PRE_LAST) begin
          state_next = S_DATA;
          cnt_next   = '0;
          out_next   = shift_reg[WIDTH-1];
          shift_next = shift_reg << 1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
          // Preamble bit 1 is '0', bit 2 is '1'.
          out_next = (cnt_reg == CW'(1));
        end
      end
      S_DATA: begin
        if (cnt_reg == DATA_LAST) begin
          state_next = S_GAP;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + CW'(1);
          out_next   = shift_reg[WIDTH-1];
          shift_next = shift_reg << 1;
        end
      end
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Handshake and status come straight from registered state.
  assign in_ready   = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign out        = out_reg;
  assign frame_done = done_reg;

endmodule
